// File: rtl/cache_4way_ctrl.sv
// Lookup/refill controller for a 4-way set-associative write-through cache array.
// Optional hit/miss counters are compiled in with CACHE_CTRL_STATS_EN.
module cache_4way_ctrl #(
    parameter int INDEX_WIDTH     = 7,
    parameter int TAG_WIDTH       = 4,
    parameter int DATA_WIDTH      = 32,
    parameter int DATA_SIZE_BYTES = 4
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic                                 i_req_valid,
    output logic                                 o_req_ready,
    input  logic                                 i_req_wen,
    input  logic [TAG_WIDTH+INDEX_WIDTH-1:0]     i_req_addr,
    input  logic [DATA_SIZE_BYTES-1:0]           i_req_ben,
    input  logic [DATA_WIDTH-1:0]                i_req_wdata,
    output logic                                 o_rsp_valid,
    output logic [DATA_WIDTH-1:0]                o_rsp_rdata,
    output logic                                 o_rsp_hit,
    output logic [3:0]                           o_way_select,
    output logic [INDEX_WIDTH-1:0]               o_cache_addr,
    output logic                                 o_cache_wen,
    output logic [DATA_SIZE_BYTES-1:0]           o_cache_ben,
    output logic [DATA_WIDTH-1:0]                o_cache_data,
    input  logic [4*DATA_WIDTH-1:0]              i_cache_data,
    output logic                                 o_tag_wen,
    output logic [TAG_WIDTH:0]                   o_tag_data,
    input  logic [4*(TAG_WIDTH+1)-1:0]           i_tag_data,
    output logic                                 o_mem_req_valid,
    input  logic                                 i_mem_req_ready,
    output logic                                 o_mem_wen,
    output logic [TAG_WIDTH+INDEX_WIDTH-1:0]     o_mem_addr,
    output logic [DATA_SIZE_BYTES-1:0]           o_mem_ben,
    output logic [DATA_WIDTH-1:0]                o_mem_wdata,
    input  logic                                 i_mem_rsp_valid,
    input  logic [DATA_WIDTH-1:0]                i_mem_rsp_rdata
`ifdef CACHE_CTRL_STATS_EN
    ,
    output logic [31:0]                          o_hit_count,
    output logic [31:0]                          o_miss_count
`endif
);
    // state   | meaning
    // INIT    | clear every tag entry, all ways at once
    // IDLE    | accept a CPU request
    // RD      | present latched index to the array
    // CMP     | compare four tags, choose hit way or victim
    // ARR_WR  | write-hit update of the data array
    // MEM_WR  | posted write-through to memory
    // MEM_RD  | miss: request word, then wait for data
    // FILL    | install refilled word and tag
    // RESP    | one-cycle response
    localparam int AW = TAG_WIDTH + INDEX_WIDTH;
    localparam int TW = TAG_WIDTH + 1;

    localparam logic [3:0] S_INIT   = 4'd0;
    localparam logic [3:0] S_IDLE   = 4'd1;
    localparam logic [3:0] S_RD     = 4'd2;
    localparam logic [3:0] S_CMP    = 4'd3;
    localparam logic [3:0] S_ARR_WR = 4'd4;
    localparam logic [3:0] S_MEM_WR = 4'd5;
    localparam logic [3:0] S_MEM_RD = 4'd6;
    localparam logic [3:0] S_FILL   = 4'd7;
    localparam logic [3:0] S_RESP   = 4'd8;

    logic [3:0]                 state_q, state_d;
    logic [INDEX_WIDTH-1:0]     init_cnt_q, init_cnt_d;
    logic [1:0]                 rr_ptr_q, rr_ptr_d;
    logic [1:0]                 way_q, way_d;
    logic                       wen_q, wen_d;
    logic [AW-1:0]              addr_q, addr_d;
    logic [DATA_SIZE_BYTES-1:0] ben_q, ben_d;
    logic [DATA_WIDTH-1:0]      wdata_q, wdata_d;
    logic [DATA_WIDTH-1:0]      rdata_q, rdata_d;
    logic                       hit_q, hit_d;
    logic                       mem_hs_q, mem_hs_d;

    logic [3:0] hit_vec, inv_vec;
    logic [1:0] hit_idx, inv_idx;
    logic [TAG_WIDTH-1:0] req_tag;

    assign req_tag = addr_q[AW-1 -: TAG_WIDTH];

    always_comb begin
        hit_vec = '0;
        inv_vec = '0;
        hit_idx = 2'd0;
        inv_idx = 2'd0;
        for (int w = 0; w < 4; w++) begin
            hit_vec[w] = i_tag_data[w*TW + TAG_WIDTH] && (i_tag_data[w*TW +: TAG_WIDTH] == req_tag);
            inv_vec[w] = !i_tag_data[w*TW + TAG_WIDTH];
        end
        // Descending scan so the lowest-numbered way wins.
        for (int w = 3; w >= 0; w--) begin
            if (hit_vec[w]) hit_idx = 2'(w);
            if (inv_vec[w]) inv_idx = 2'(w);
        end
    end

    always_comb begin
        state_d    = state_q;
        init_cnt_d = init_cnt_q;
        rr_ptr_d   = rr_ptr_q;
        way_d      = way_q;
        wen_d      = wen_q;
        addr_d     = addr_q;
        ben_d      = ben_q;
        wdata_d    = wdata_q;
        rdata_d    = rdata_q;
        hit_d      = hit_q;
        mem_hs_d   = mem_hs_q;
        case (state_q)
            S_INIT: begin
                init_cnt_d = init_cnt_q + 1'b1;
                if (init_cnt_q == '1) state_d = S_IDLE;
            end
            S_IDLE: begin
                mem_hs_d = 1'b0;
                if (i_req_valid) begin
                    wen_d   = i_req_wen;
                    addr_d  = i_req_addr;
                    ben_d   = i_req_ben;
                    wdata_d = i_req_wdata;
                    state_d = S_RD;
                end
            end
            S_RD: state_d = S_CMP;
            S_CMP: begin
                rdata_d = '0;
                hit_d   = |hit_vec;
                if (|hit_vec) begin
                    way_d = hit_idx;
                    if (wen_q) state_d = S_ARR_WR;
                    else begin
                        rdata_d = i_cache_data[int'(hit_idx)*DATA_WIDTH +: DATA_WIDTH];
                        state_d = S_RESP;
                    end
                end else if (wen_q) begin
                    state_d = S_MEM_WR;
                end else begin
                    state_d = S_MEM_RD;
                    if (|inv_vec) way_d = inv_idx;
                    else begin
                        way_d    = rr_ptr_q;
                        rr_ptr_d = rr_ptr_q + 2'd1;
                    end
                end
            end
            S_ARR_WR: state_d = S_MEM_WR;
            S_MEM_WR: if (i_mem_req_ready) state_d = S_RESP;
            S_MEM_RD: begin
                // Read data only counts once the request itself has been accepted.
                if (!mem_hs_q) begin
                    if (i_mem_req_ready) mem_hs_d = 1'b1;
                end else if (i_mem_rsp_valid) begin
                    rdata_d  = i_mem_rsp_rdata;
                    mem_hs_d = 1'b0;
                    state_d  = S_FILL;
                end
            end
            S_FILL: state_d = S_RESP;
            S_RESP: state_d = S_IDLE;
            default: state_d = S_INIT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_INIT;
            init_cnt_q <= '0;
            rr_ptr_q   <= '0;
            way_q      <= '0;
            wen_q      <= 1'b0;
            addr_q     <= '0;
            ben_q      <= '0;
            wdata_q    <= '0;
            rdata_q    <= '0;
            hit_q      <= 1'b0;
            mem_hs_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            init_cnt_q <= init_cnt_d;
            rr_ptr_q   <= rr_ptr_d;
            way_q      <= way_d;
            wen_q      <= wen_d;
            addr_q     <= addr_d;
            ben_q      <= ben_d;
            wdata_q    <= wdata_d;
            rdata_q    <= rdata_d;
            hit_q      <= hit_d;
            mem_hs_q   <= mem_hs_d;
        end
    end

    // Outputs hold their reset values for as long as reset is asserted.
    always_comb begin
        o_req_ready     = 1'b0;
        o_rsp_valid     = 1'b0;
        o_rsp_rdata     = '0;
        o_rsp_hit       = 1'b0;
        o_way_select    = 4'b0000;
        o_cache_addr    = '0;
        o_cache_wen     = 1'b0;
        o_cache_ben     = '0;
        o_cache_data    = '0;
        o_tag_wen       = 1'b0;
        o_tag_data      = '0;
        o_mem_req_valid = 1'b0;
        o_mem_wen       = 1'b0;
        o_mem_addr      = '0;
        o_mem_ben       = '0;
        o_mem_wdata     = '0;
        if (!reset) begin
            o_cache_addr = addr_q[INDEX_WIDTH-1:0];
            case (state_q)
                S_INIT: begin
                    o_cache_addr = init_cnt_q;
                    o_tag_wen    = 1'b1;
                    o_way_select = 4'b1111;
                end
                S_IDLE: o_req_ready = 1'b1;
                S_ARR_WR: begin
                    o_cache_wen  = 1'b1;
                    o_way_select = 4'b0001 << way_q;
                    o_cache_ben  = ben_q;
                    o_cache_data = wdata_q;
                end
                S_MEM_WR: begin
                    o_mem_req_valid = 1'b1;
                    o_mem_wen       = 1'b1;
                    o_mem_addr      = addr_q;
                    o_mem_ben       = ben_q;
                    o_mem_wdata     = wdata_q;
                end
                S_MEM_RD: begin
                    if (!mem_hs_q) begin
                        o_mem_req_valid = 1'b1;
                        o_mem_addr      = addr_q;
                        o_mem_ben       = '1;
                    end
                end
                S_FILL: begin
                    o_cache_wen  = 1'b1;
                    o_cache_ben  = '1;
                    o_cache_data = rdata_q;
                    o_tag_wen    = 1'b1;
                    o_tag_data   = {1'b1, req_tag};
                    o_way_select = 4'b0001 << way_q;
                end
                S_RESP: begin
                    o_rsp_valid = 1'b1;
                    o_rsp_rdata = rdata_q;
                    o_rsp_hit   = hit_q;
                end
                default: ;
            endcase
        end
    end

`ifdef CACHE_CTRL_STATS_EN
    logic [31:0] hit_cnt_q, miss_cnt_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
        end else if (state_q == S_CMP) begin
            if (|hit_vec) hit_cnt_q  <= hit_cnt_q + 32'd1;
            else          miss_cnt_q <= miss_cnt_q + 32'd1;
        end
    end

    assign o_hit_count  = hit_cnt_q;
    assign o_miss_count = miss_cnt_q;
`endif

endmodule

// File: tb/tb_cache_4way_ctrl.sv
// Scoreboard bench for cache_4way_ctrl: array and memory models plus a set/way reference model.
module tb_cache_4way_ctrl;
    logic         clk = 1'b0;
    logic         reset;
    logic         i_req_valid, i_req_wen;
    logic [10:0]  i_req_addr;
    logic [3:0]   i_req_ben;
    logic [31:0]  i_req_wdata;
    logic         o_req_ready, o_rsp_valid, o_rsp_hit;
    logic [31:0]  o_rsp_rdata;
    logic [3:0]   o_way_select;
    logic [6:0]   o_cache_addr;
    logic         o_cache_wen, o_tag_wen;
    logic [3:0]   o_cache_ben;
    logic [31:0]  o_cache_data;
    logic [127:0] i_cache_data;
    logic [4:0]   o_tag_data;
    logic [19:0]  i_tag_data;
    logic         o_mem_req_valid, i_mem_req_ready, o_mem_wen;
    logic [10:0]  o_mem_addr;
    logic [3:0]   o_mem_ben;
    logic [31:0]  o_mem_wdata;
    logic         i_mem_rsp_valid;
    logic [31:0]  i_mem_rsp_rdata;

    always #5 clk = ~clk;

    cache_4way_ctrl dut (
        .clk(clk), .reset(reset),
        .i_req_valid(i_req_valid), .o_req_ready(o_req_ready), .i_req_wen(i_req_wen),
        .i_req_addr(i_req_addr), .i_req_ben(i_req_ben), .i_req_wdata(i_req_wdata),
        .o_rsp_valid(o_rsp_valid), .o_rsp_rdata(o_rsp_rdata), .o_rsp_hit(o_rsp_hit),
        .o_way_select(o_way_select), .o_cache_addr(o_cache_addr), .o_cache_wen(o_cache_wen),
        .o_cache_ben(o_cache_ben), .o_cache_data(o_cache_data), .i_cache_data(i_cache_data),
        .o_tag_wen(o_tag_wen), .o_tag_data(o_tag_data), .i_tag_data(i_tag_data),
        .o_mem_req_valid(o_mem_req_valid), .i_mem_req_ready(i_mem_req_ready), .o_mem_wen(o_mem_wen),
        .o_mem_addr(o_mem_addr), .o_mem_ben(o_mem_ben), .o_mem_wdata(o_mem_wdata),
        .i_mem_rsp_valid(i_mem_rsp_valid), .i_mem_rsp_rdata(i_mem_rsp_rdata)
    );

    int n_cmp = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] init_word(input logic [10:0] a);
        if (a == 11'h2A5) return 32'hDEADBEEF;
        return ({21'h0, a} * 32'h9E3779B1) ^ 32'h5A5A0F0F;
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw, input logic [3:0] ben);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) if (ben[b]) r[8*b +: 8] = nw[8*b +: 8];
        return r;
    endfunction

    typedef struct packed { logic [31:0] rdata; logic hit; } rsp_t;
    typedef struct packed { logic [3:0] way; logic [4:0] tag; logic [6:0] idx; logic [31:0] data; logic [3:0] ben; } arr_t;
    typedef struct packed { logic wen; logic [10:0] addr; logic [3:0] ben; logic [31:0] wdata; } mem_t;
    rsp_t sb_q[$];
    arr_t fill_q[$];
    arr_t awr_q[$];
    mem_t mem_q[$];

    // Reference model: per-set valid/tag table, global round-robin pointer, backing memory image.
    logic        ref_v [128][4];
    logic [3:0]  ref_t [128][4];
    int          ref_rr;
    logic [31:0] ref_mem [2048];

    // Environment controls
    bit force_low = 0;
    bit stray_en = 0;
    int dly_min = 1;
    int dly_max = 4;
    int pend = 0;

    // Array model: one-cycle read latency; stale random contents while reset is held.
    logic [31:0] arr_data [4][128];
    logic [4:0]  arr_tag  [4][128];
    always @(posedge clk) begin
        if (reset) begin
            for (int w = 0; w < 4; w++)
                for (int i = 0; i < 128; i++) begin
                    arr_tag[w][i]  <= 5'($urandom);
                    arr_data[w][i] <= $urandom;
                end
        end else begin
            for (int w = 0; w < 4; w++) if (o_way_select[w]) begin
                if (o_tag_wen) arr_tag[w][o_cache_addr] <= o_tag_data;
                if (o_cache_wen)
                    for (int b = 0; b < 4; b++)
                        if (o_cache_ben[b]) arr_data[w][o_cache_addr][8*b +: 8] <= o_cache_data[8*b +: 8];
            end
        end
        for (int w = 0; w < 4; w++) begin
            i_cache_data[w*32 +: 32] <= arr_data[w][o_cache_addr];
            i_tag_data[w*5 +: 5]     <= arr_tag[w][o_cache_addr];
        end
    end

    // Memory responder and memory-request checker
    logic [31:0] mem_store [2048];
    logic [31:0] pend_data;
    initial begin
        mem_t e;
        for (int a = 0; a < 2048; a++) mem_store[a] = init_word(11'(a));
        i_mem_req_ready = 0;
        i_mem_rsp_valid = 0;
        i_mem_rsp_rdata = 0;
        forever begin
            @(negedge clk);
            i_mem_rsp_valid = 0;
            i_mem_rsp_rdata = $urandom;
            if (pend > 0) begin
                pend--;
                if (pend == 0) begin
                    i_mem_rsp_valid = 1;
                    i_mem_rsp_rdata = pend_data;
                end
            end else if (stray_en && $urandom_range(0, 7) == 0) begin
                i_mem_rsp_valid = 1;
            end
            i_mem_req_ready = force_low ? 1'b0 : ($urandom_range(0, 3) != 0);
            if (o_mem_req_valid && i_mem_req_ready) begin
                if (mem_q.size() == 0) check("mem_req_unexpected", 1, 0);
                else begin
                    e = mem_q.pop_front();
                    check("mem_wen", o_mem_wen, e.wen);
                    check("mem_addr", o_mem_addr, e.addr);
                    check("mem_ben", o_mem_ben, e.ben);
                    if (e.wen) check("mem_wdata", o_mem_wdata, e.wdata);
                end
                if (o_mem_wen) mem_store[o_mem_addr] = merge(mem_store[o_mem_addr], o_mem_wdata, o_mem_ben);
                else begin
                    pend = $urandom_range(dly_min, dly_max);
                    pend_data = mem_store[o_mem_addr];
                end
            end
        end
    end

    // Response / array-write monitor
    initial begin
        rsp_t r;
        arr_t a;
        forever begin
            @(negedge clk);
            if (o_rsp_valid) begin
                if (sb_q.size() == 0) check("rsp_unexpected", 1, 0);
                else begin
                    r = sb_q.pop_front();
                    check("rsp_rdata", o_rsp_rdata, r.rdata);
                    check("rsp_hit", o_rsp_hit, r.hit);
                end
            end
            if (o_tag_wen && o_way_select != 4'hF) begin
                if (fill_q.size() == 0) check("fill_unexpected", 1, 0);
                else begin
                    a = fill_q.pop_front();
                    check("fill_way", o_way_select, a.way);
                    check("fill_tag", o_tag_data, a.tag);
                    check("fill_idx", o_cache_addr, a.idx);
                    check("fill_data", o_cache_data, a.data);
                    check("fill_wen_ben", {o_cache_wen, o_cache_ben}, 5'h1F);
                end
            end else if (o_cache_wen) begin
                if (awr_q.size() == 0) check("arr_wr_unexpected", 1, 0);
                else begin
                    a = awr_q.pop_front();
                    check("arr_wr_way", o_way_select, a.way);
                    check("arr_wr_idx", o_cache_addr, a.idx);
                    check("arr_wr_ben", o_cache_ben, a.ben);
                    check("arr_wr_data", o_cache_data, a.data);
                end
            end
            if (!(o_cache_wen || o_tag_wen)) check("way_sel_without_strobe", o_way_select, 0);
        end
    end

    function automatic void ref_reset();
        for (int i = 0; i < 128; i++)
            for (int w = 0; w < 4; w++) ref_v[i][w] = 0;
        ref_rr = 0;
    endfunction

    task automatic issue(input logic wen, input logic [10:0] addr, input logic [3:0] ben,
                         input logic [31:0] wdata, input bit wait_rsp, output int lat);
        int n, hw, v;
        logic [6:0] idx;
        logic [3:0] tag;
        idx = addr[6:0];
        tag = addr[10:7];
        lat = 0;
        n = 0;
        while (!o_req_ready && n < 400) begin @(negedge clk); n++; end
        if (!o_req_ready) begin check("req_ready_timeout", 0, 1); return; end
        hw = -1;
        for (int w = 3; w >= 0; w--) if (ref_v[idx][w] && ref_t[idx][w] == tag) hw = w;
        if (wen) begin
            if (hw >= 0) awr_q.push_back('{4'(1 << hw), 5'h0, idx, wdata, ben});
            mem_q.push_back('{1'b1, addr, ben, wdata});
            sb_q.push_back('{32'h0, hw >= 0});
            ref_mem[addr] = merge(ref_mem[addr], wdata, ben);
        end else if (hw >= 0) begin
            sb_q.push_back('{ref_mem[addr], 1'b1});
        end else begin
            v = -1;
            for (int w = 3; w >= 0; w--) if (!ref_v[idx][w]) v = w;
            if (v < 0) begin v = ref_rr; ref_rr = (ref_rr + 1) % 4; end
            ref_v[idx][v] = 1;
            ref_t[idx][v] = tag;
            mem_q.push_back('{1'b0, addr, 4'hF, 32'h0});
            fill_q.push_back('{4'(1 << v), {1'b1, tag}, idx, ref_mem[addr], 4'hF});
            sb_q.push_back('{ref_mem[addr], 1'b0});
        end
        i_req_valid = 1; i_req_wen = wen; i_req_addr = addr; i_req_ben = ben; i_req_wdata = wdata;
        @(posedge clk);
        #1 i_req_valid = 0;
        if (wait_rsp) begin
            n = 0;
            do begin @(negedge clk); n++; end while (!o_rsp_valid && n < 400);
            lat = n;
            if (!o_rsp_valid) check("rsp_timeout", 0, 1);
        end
    endtask

    // Called just after reset is released; watches the tag-clear sweep through to ready.
    task automatic init_watch();
        int n, bad, rsp, memv;
        n = 0; bad = 0; rsp = 0; memv = 0;
        do begin
            @(negedge clk);
            n++;
            if (!o_req_ready && !(o_tag_wen && o_way_select == 4'hF && o_cache_addr == 7'(n - 1)
                                  && o_tag_data == 5'h0 && !o_cache_wen)) bad++;
            rsp += int'(o_rsp_valid);
            memv += int'(o_mem_req_valid);
        end while (!o_req_ready && n < 400);
        check("init_cycles_to_ready", n, 129);
        check("init_bad_cycles", bad, 0);
        check("init_rsp_valid_count", rsp, 0);
        check("init_mem_req_count", memv, 0);
    endtask

    task automatic do_reset(input int cycles);
        reset = 1;
        repeat (cycles) @(posedge clk);
        sb_q.delete(); fill_q.delete(); awr_q.delete(); mem_q.delete();
        ref_reset();
        #1 reset = 0;
        init_watch();
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        logic [10:0] a;
        for (int i = 0; i < 2048; i++) ref_mem[i] = init_word(11'(i));
        ref_reset();
        reset = 1;
        i_req_valid = 0; i_req_wen = 0; i_req_addr = 0; i_req_ben = 0; i_req_wdata = 0;

        @(negedge clk);
        check("reset_outputs", {o_req_ready, o_rsp_valid, o_rsp_hit, o_cache_wen, o_tag_wen,
                                o_mem_req_valid, o_way_select, o_cache_addr}, 0);
        @(posedge clk);
        #1 reset = 0;
        init_watch();

        // cold read, repeat read, partial write, merged read
        issue(0, 11'h2A5, 4'hF, 0, 1, lat);
        issue(0, 11'h2A5, 4'hF, 0, 1, lat);
        check("read_hit_latency", lat, 3);
        issue(1, 11'h2A5, 4'b0011, 32'h0000CAFE, 1, lat);
        issue(0, 11'h2A5, 4'hF, 0, 1, lat);
        check("merged_read_latency", lat, 3);

        // fill set 0x10 with tags 1..4, then round-robin victims
        for (int t = 1; t <= 4; t++) issue(0, {4'(t), 7'h10}, 4'hF, 0, 1, lat);
        issue(0, {4'd6, 7'h10}, 4'hF, 0, 1, lat);
        issue(0, {4'd7, 7'h10}, 4'hF, 0, 1, lat);
        issue(0, {4'd1, 7'h10}, 4'hF, 0, 1, lat);

        // randomized traffic over a few sets and tags
        stray_en = 1;
        for (int i = 0; i < 250; i++) begin
            a = {4'($urandom_range(0, 5)), 7'($urandom_range(0, 3))};
            issue(($urandom_range(0, 9) < 3), a, 4'($urandom), $urandom, 1, lat);
        end
        stray_en = 0;

        // reset while a memory request is still being offered
        force_low = 1;
        issue(0, 11'h2C4, 4'hF, 0, 0, lat);
        repeat (3) @(negedge clk);
        check("mem_req_held", o_mem_req_valid, 1);
        reset = 1;
        @(negedge clk);
        check("mem_req_dropped_on_reset", o_mem_req_valid, 0);
        force_low = 0;
        do_reset(1);

        // reset while waiting for read data; the late response lands during INIT
        dly_min = 10; dly_max = 10;
        issue(0, 11'h1D3, 4'hF, 0, 0, lat);
        lat = 0;
        while (pend == 0 && lat < 200) begin @(negedge clk); lat++; end
        check("mem_read_accepted", pend != 0, 1);
        @(negedge clk);
        check("waiting_no_mem_req", o_mem_req_valid, 0);
        do_reset(1);
        dly_min = 1; dly_max = 4;

        issue(0, 11'h1D3, 4'hF, 0, 1, lat);
        issue(0, 11'h1D3, 4'hF, 0, 1, lat);
        check("post_reset_hit_latency", lat, 3);

        repeat (5) @(negedge clk);
        check("sb_drained", sb_q.size() + fill_q.size() + awr_q.size() + mem_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
